sc_regshift_tx: RTL and testbench
=================================

SC_REGSHIFT_TX -- requirements
Module: sc_regshift_tx

Interface
REQ-001 SHALL have parameter: RegSHIFTTX_DATAWIDTH, default 8, width of the parallel word (legal range 2..32).
REQ-002 SHALL have port: SC_RegSHIFTTX_CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: SC_RegSHIFTTX_RESET_InLow  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: SC_RegSHIFTTX_start_InHigh  input  1  request to transmit the word on data_InBUS.
REQ-005 SHALL have port: SC_RegSHIFTTX_clear_InHigh  input  1  synchronous abort of any frame in progress.
REQ-006 SHALL have port: SC_RegSHIFTTX_data_InBUS  input  DATAWIDTH  parallel word, normally driven by a general register's output bus.
REQ-007 SHALL have port: SC_RegSHIFTTX_serial_Out  output  1  serial bit stream, MSB first; idle level 1.
REQ-008 SHALL have port: SC_RegSHIFTTX_busy_Out  output  1  high while a frame occupies the block.
REQ-009 SHALL have port: SC_RegSHIFTTX_done_Out  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 SHALL drive serial_Out, busy_Out and done_Out directly from registers, with no combinational path from any input.
REQ-012 In IDLE, start=1 and clear=0 at an edge SHALL capture data_InBUS into the shift register, zero the bit counter and enter SHIFT.
REQ-013 SHALL drive serial_Out = data[W-1-k] during the k-th cycle of SHIFT (k=0..W-1), so the first bit appears in the cycle after the capture edge.
REQ-014 In SHIFT, each edge SHALL shift left by one and increment the counter; after the W-th SHIFT cycle the next edge SHALL enter DONE.
REQ-015 busy_Out SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-016 In DONE, done_Out SHALL be 1 and serial_Out SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing, and data_InBUS changes after capture SHALL have no effect.
REQ-018 clear=1 at any edge SHALL force IDLE, serial_Out=1, busy_Out=0, done_Out=0 and counter=0, with no done pulse; clear has priority over start.
REQ-019 With start held high continuously, a new frame SHALL start at the IDLE edge following DONE, giving one idle cycle between frames (frame period W+2 cycles).
REQ-020 The counter SHALL be clog2(W) bits wide and SHALL never wrap within a frame.

Reset
REQ-021 While RESET_InLow=0, independent of the clock: state=IDLE, shift register=0, counter=0, serial_Out=1, busy_Out=0, done_Out=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after deassertion SHALL be handled per REQ-012.

Structure
REQ-023 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the counter-width function SHALL reside in shared package sc_regshift_pkg.
REQ-024 The bit counter SHALL be a sub-module, sc_bit_counter, with clear, enable, count and terminal-count outputs; the FSM and shift register SHALL stay in the top module.

Verification
REQ-025 Reset check: assert reset -> serial_Out=1, busy_Out=0, done_Out=0 immediately, without any clock edge.
REQ-026 Single frame: W=8, start pulse with data=8'hA5 -> serial 1,0,1,0,0,1,0,1 in cycles 1..8, done_Out=1 in cycle 9 only, busy_Out=1 in cycles 1..9.
REQ-027 Start while busy: start pulse with 8'h3C during cycle 4 of an 8'hA5 frame -> 8'hA5 stream unaltered, no second frame.
REQ-028 Clear mid-frame: clear at cycle 3 -> serial_Out=1 and busy_Out=0 next cycle, no done pulse; a later start with 8'hFF transmits eight 1s.
REQ-029 Back-to-back: start held high with data 8'h81 -> frames begin every 10 cycles, each 1,0,0,0,0,0,0,1 followed by a done pulse.
REQ-030 Reset mid-frame: reset at cycle 5, then release -> outputs at reset values, and the next start with 8'h55 transmits correctly.

Source files
------------

// File: rtl/sc_regshift_pkg.sv
// Shared state encodings and sizing helper for the register-to-serial transmitter.
package sc_regshift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit-counter width: indexes 0..W-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sc_regshift_tx_if.sv
// Bundle of the transmitter's request/status signals with driver and block views.
interface sc_regshift_tx_if #(parameter int DW = 8);
  logic          start;
  logic          clear;
  logic [DW-1:0] data;
  logic          serial;
  logic          busy;
  logic          done;

  modport master (output start, clear, data, input  serial, busy, done);
  modport slave  (input  start, clear, data, output serial, busy, done);
endinterface

// File: rtl/sc_regshift_tx_bit_counter.sv
// Frame bit counter: synchronous clear beats enable; tc flags the last bit index.
module sc_bit_counter
  import sc_regshift_pkg::*;
#(
  parameter int W = 8,
  localparam int CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);
endmodule

// File: rtl/sc_regshift_tx.sv
// Parallel-to-serial transmitter: captures a register word, shifts it out MSB first,
// then pulses done. All outputs come straight from flops.
module sc_regshift_tx
  import sc_regshift_pkg::*;
#(
  parameter int RegSHIFTTX_DATAWIDTH = 8
) (
  input  logic                            SC_RegSHIFTTX_CLOCK_50,
  input  logic                            SC_RegSHIFTTX_RESET_InLow,
  input  logic                            SC_RegSHIFTTX_start_InHigh,
  input  logic                            SC_RegSHIFTTX_clear_InHigh,
  input  logic [RegSHIFTTX_DATAWIDTH-1:0] SC_RegSHIFTTX_data_InBUS,
  output logic                            SC_RegSHIFTTX_serial_Out,
  output logic                            SC_RegSHIFTTX_busy_Out,
  output logic                            SC_RegSHIFTTX_done_Out
);
  localparam int W  = RegSHIFTTX_DATAWIDTH;
  localparam int CW = cnt_width(W);

  logic clk, rst_n;
  assign clk   = SC_RegSHIFTTX_CLOCK_50;
  assign rst_n = SC_RegSHIFTTX_RESET_InLow;

  state_e        state_q;
  // The MSB goes straight into serial_q at capture; sreg_q holds the bits still to send.
  logic [W-2:0]  sreg_q;
  logic          serial_q, busy_q, done_q;

  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt;

  assign cnt_en  = (state_q == ST_SHIFT);
  assign cnt_clr = SC_RegSHIFTTX_clear_InHigh || (state_q != ST_SHIFT) || cnt_tc;

  sc_bit_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (SC_RegSHIFTTX_clear_InHigh) begin
      state_q  <= ST_IDLE;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          if (SC_RegSHIFTTX_start_InHigh) begin
            state_q  <= ST_SHIFT;
            sreg_q   <= SC_RegSHIFTTX_data_InBUS[W-2:0];
            serial_q <= SC_RegSHIFTTX_data_InBUS[W-1];
            busy_q   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_tc) begin
            state_q  <= ST_DONE;
            serial_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            serial_q <= sreg_q[W-2];
            sreg_q   <= sreg_q << 1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(W - 1));

  assign SC_RegSHIFTTX_serial_Out = serial_q;
  assign SC_RegSHIFTTX_busy_Out   = busy_q;
  assign SC_RegSHIFTTX_done_Out   = done_q;
endmodule

// File: tb/tb_sc_regshift_tx.sv
// Scoreboard bench for sc_regshift_tx: stimulus queues expected per-cycle serial/done
// while busy; the monitor checks every cycle on the falling edge.
module tb_sc_regshift_tx;
  localparam int W = 8;

  typedef struct packed {
    logic ser;
    logic dn;
  } exp_t;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   ncmp;
  int   nerr;
  exp_t q[$];

  sc_regshift_tx_if #(.DW(W)) bus ();

  sc_regshift_tx #(.RegSHIFTTX_DATAWIDTH(W)) dut (
    .SC_RegSHIFTTX_CLOCK_50     (clk),
    .SC_RegSHIFTTX_RESET_InLow  (rst_n),
    .SC_RegSHIFTTX_start_InHigh (bus.start),
    .SC_RegSHIFTTX_clear_InHigh (bus.clear),
    .SC_RegSHIFTTX_data_InBUS   (bus.data),
    .SC_RegSHIFTTX_serial_Out   (bus.serial),
    .SC_RegSHIFTTX_busy_Out     (bus.busy),
    .SC_RegSHIFTTX_done_Out     (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back('{ser: d[i], dn: 1'b0});
    q.push_back('{ser: 1'b1, dn: 1'b1});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sits just after a rising edge; capture happens on the next one.
  task automatic send(input logic [W-1:0] d);
    push_frame(d);
    bus.start = 1'b1;
    bus.data  = d;
    cyc(1);
    bus.start = 1'b0;
    bus.data  = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy) begin
        if (q.size() == 0) begin
          chk("busy_without_frame", bus.busy, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("serial", bus.serial, e.ser);
          chk("done", bus.done, e.dn);
        end
      end else begin
        chk("idle_serial", bus.serial, 1'b1);
        chk("idle_done", bus.done, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ncmp      = 0;
    nerr      = 0;
    mon_en    = 1'b0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.data  = '0;

    // Async reset takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_serial", bus.serial, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    cyc(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(2);

    // Single frame A5.
    send(8'hA5);
    cyc(12);

    // Start with 3C during cycle 4 of an A5 frame is ignored.
    send(8'hA5);
    cyc(3);
    bus.start = 1'b1;
    bus.data  = 8'h3C;
    cyc(1);
    bus.start = 1'b0;
    bus.data  = '0;
    cyc(10);

    // Clear during cycle 3 aborts; then FF transmits all ones.
    send(8'h96);
    cyc(2);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    q.delete();
    chk("clr_serial", bus.serial, 1'b1);
    chk("clr_busy", bus.busy, 1'b0);
    chk("clr_done", bus.done, 1'b0);
    cyc(2);
    send(8'hFF);
    cyc(12);

    // Back-to-back 81 with start held: captures every 10 cycles, three frames.
    push_frame(8'h81);
    push_frame(8'h81);
    push_frame(8'h81);
    bus.start = 1'b1;
    bus.data  = 8'h81;
    cyc(21);
    bus.start = 1'b0;
    bus.data  = '0;
    cyc(12);

    // Reset during cycle 5, then a clean 55 frame.
    send(8'hA5);
    cyc(4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_serial", bus.serial, 1'b1);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send(8'h55);
    cyc(12);

    chk("queue_drained", (q.size() == 0), 1'b1);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
